sobel_conv_seq: RTL and testbench

Parametrised sequential 3x3 Sobel engine for the convolution datapath. It accepts one 3x3 pixel window through a valid/ready handshake and accumulates both gradients tap by tap, one tap per cycle. It then produces a selectable magnitude, saturated to pixel width, plus an edge flag, and holds the result under output back-pressure. It sits between the line-buffer/window generator and the result writer of the coprocessor.

---
 rtl/sobel_conv_seq.sv | 164 ++++++++++++++++
 tb/tb_sobel_conv_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_conv_seq.sv
// Sequential 3x3 Sobel engine: accepts one window, walks the nine taps one per cycle,
// then registers a selectable saturated magnitude, an edge flag and both gradients.
module sobel_conv_seq #(
    parameter  int PIX_W = 8,
    parameter  int SHIFT = 0,
    localparam int ACC_W = PIX_W + 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3*PIX_W-1:0]      linha1,
    input  logic [3*PIX_W-1:0]      linha2,
    input  logic [3*PIX_W-1:0]      linha3,
    input  logic [1:0]              mode,
    input  logic [PIX_W-1:0]        threshold,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PIX_W-1:0]        resultado,
    output logic                    edge_flag,
    output logic signed [ACC_W-1:0] gx,
    output logic signed [ACC_W-1:0] gy,
    output logic                    busy
);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_MAG, S_OUT} state_t;

    localparam logic [ACC_W:0] PIX_MAX = (ACC_W + 1)'((1 << PIX_W) - 1);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [PIX_W-1:0]          r_pix [9];
    logic [3:0]                r_tap;
    logic [1:0]                r_mode;
    logic [PIX_W-1:0]          r_thr;
    logic signed [ACC_W-1:0]   r_gx_acc;
    logic signed [ACC_W-1:0]   r_gy_acc;
    logic [PIX_W-1:0]          r_res;
    logic                      r_edge;
    logic signed [ACC_W-1:0]   r_gx;
    logic signed [ACC_W-1:0]   r_gy;

    logic [3*PIX_W-1:0]        w_rows [3];
    logic [PIX_W-1:0]          w_win [9];
    logic                      w_accept;
    logic [PIX_W-1:0]          w_pix;
    logic signed [ACC_W-1:0]   w_p1;
    logic signed [ACC_W-1:0]   w_p2;
    logic signed [ACC_W-1:0]   w_gx_term;
    logic signed [ACC_W-1:0]   w_gy_term;
    logic [ACC_W-1:0]          w_ax;
    logic [ACC_W-1:0]          w_ay;
    logic [ACC_W:0]            w_mag;
    logic [ACC_W:0]            w_shifted;
    logic [PIX_W-1:0]          w_sat;

    assign w_rows[0] = linha1;
    assign w_rows[1] = linha2;
    assign w_rows[2] = linha3;

    // Unpack the window row-major; column 0 sits in the MSBs of each row.
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_tap
            assign w_win[gi] = w_rows[gi / 3][(2 - gi % 3) * PIX_W +: PIX_W];
        end
    endgenerate

    assign in_ready  = (r_state == S_IDLE) && rst;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == S_OUT);
    assign busy      = (r_state != S_IDLE);
    assign resultado = r_res;
    assign edge_flag = r_edge;
    assign gx        = r_gx;
    assign gy        = r_gy;

    assign w_pix = r_pix[r_tap];
    assign w_p1  = $signed({{(ACC_W - PIX_W){1'b0}}, w_pix});
    assign w_p2  = w_p1 <<< 1;

    // Gx = left column minus right column, Gy = bottom row minus top row.
    always_comb begin
        w_gx_term = '0;
        w_gy_term = '0;
        case (r_tap)
            4'd0: begin w_gx_term =  w_p1; w_gy_term = -w_p1; end
            4'd1: begin                    w_gy_term = -w_p2; end
            4'd2: begin w_gx_term = -w_p1; w_gy_term = -w_p1; end
            4'd3: begin w_gx_term =  w_p2;                    end
            4'd5: begin w_gx_term = -w_p2;                    end
            4'd6: begin w_gx_term =  w_p1; w_gy_term =  w_p1; end
            4'd7: begin                    w_gy_term =  w_p2; end
            4'd8: begin w_gx_term = -w_p1; w_gy_term =  w_p1; end
            default: ;
        endcase
    end

    assign w_ax = r_gx_acc[ACC_W-1] ? -r_gx_acc : r_gx_acc;
    assign w_ay = r_gy_acc[ACC_W-1] ? -r_gy_acc : r_gy_acc;

    always_comb begin
        w_mag = '0;
        case (r_mode)
            2'd0: w_mag = {1'b0, w_ax} + {1'b0, w_ay};
            2'd1: w_mag = {1'b0, w_ax};
            2'd2: w_mag = {1'b0, w_ay};
            2'd3: w_mag = (w_ax > w_ay) ? {1'b0, w_ax} : {1'b0, w_ay};
            default: ;
        endcase
    end

    assign w_shifted = w_mag >> SHIFT;
    assign w_sat     = (w_shifted > PIX_MAX) ? '1 : w_shifted[PIX_W-1:0];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_ACC;
            S_ACC:   if (r_tap == 4'd8) w_state_next = S_MAG;
            S_MAG:   w_state_next = S_OUT;
            S_OUT:   if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_tap    <= '0;
            r_gx_acc <= '0;
            r_gy_acc <= '0;
            r_res    <= '0;
            r_edge   <= 1'b0;
            r_gx     <= '0;
            r_gy     <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    for (int i = 0; i < 9; i++) r_pix[i] <= w_win[i];
                    r_mode   <= mode;
                    r_thr    <= threshold;
                    r_tap    <= '0;
                    r_gx_acc <= '0;
                    r_gy_acc <= '0;
                end
                S_ACC: begin
                    r_gx_acc <= r_gx_acc + w_gx_term;
                    r_gy_acc <= r_gy_acc + w_gy_term;
                    r_tap    <= r_tap + 4'd1;
                end
                S_MAG: begin
                    r_res  <= w_sat;
                    r_edge <= (w_sat >= r_thr);
                    r_gx   <= r_gx_acc;
                    r_gy   <= r_gy_acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_conv_seq.sv
// Bench for sobel_conv_seq: two instances (SHIFT=0 and SHIFT=2) run in lockstep and are
// compared against a kernel-sum reference model on directed and random windows.
module tb_sobel_conv_seq;

    localparam int PIX_W = 8;
    localparam int ACC_W = PIX_W + 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst, in_valid, out_ready;
    logic [3*PIX_W-1:0]      linha1, linha2, linha3;
    logic [1:0]              mode;
    logic [PIX_W-1:0]        threshold;

    logic                    in_ready0, out_valid0, edge0, busy0;
    logic [PIX_W-1:0]        res0;
    logic signed [ACC_W-1:0] gx0, gy0;
    logic                    in_ready2, out_valid2, edge2, busy2;
    logic [PIX_W-1:0]        res2;
    logic signed [ACC_W-1:0] gx2, gy2;

    sobel_conv_seq #(.PIX_W(PIX_W), .SHIFT(0)) u_s0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .linha1(linha1), .linha2(linha2), .linha3(linha3), .mode(mode),
        .threshold(threshold), .out_valid(out_valid0), .out_ready(out_ready),
        .resultado(res0), .edge_flag(edge0), .gx(gx0), .gy(gy0), .busy(busy0)
    );

    sobel_conv_seq #(.PIX_W(PIX_W), .SHIFT(2)) u_s2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .linha1(linha1), .linha2(linha2), .linha3(linha3), .mode(mode),
        .threshold(threshold), .out_valid(out_valid2), .out_ready(out_ready),
        .resultado(res2), .edge_flag(edge2), .gx(gx2), .gy(gy2), .busy(busy2)
    );

    int total = 0;
    int bad   = 0;
    int win [3][3];
    int kx [3][3] = '{'{1, 0, -1}, '{2, 0, -2}, '{1, 0, -1}};
    int ky [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};
    int e_gx, e_gy, e_res0, e_res2, e_edge0, e_edge2;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat_mag(input int md, input int ax, input int ay, input int sh);
        int m;
        case (md)
            0: m = ax + ay;
            1: m = ax;
            2: m = ay;
            default: m = (ax > ay) ? ax : ay;
        endcase
        m = m >> sh;
        return (m > 255) ? 255 : m;
    endfunction

    task automatic model(input int md, input int thr);
        int ax, ay;
        e_gx = 0;
        e_gy = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                e_gx += kx[r][c] * win[r][c];
                e_gy += ky[r][c] * win[r][c];
            end
        ax = (e_gx < 0) ? -e_gx : e_gx;
        ay = (e_gy < 0) ? -e_gy : e_gy;
        e_res0  = sat_mag(md, ax, ay, 0);
        e_res2  = sat_mag(md, ax, ay, 2);
        e_edge0 = (e_res0 >= thr) ? 1 : 0;
        e_edge2 = (e_res2 >= thr) ? 1 : 0;
    endtask

    task automatic fill_cols(input int a, input int b, input int c);
        for (int r = 0; r < 3; r++) begin
            win[r][0] = a;
            win[r][1] = b;
            win[r][2] = c;
        end
    endtask

    task automatic fill_row(input int r, input int v);
        for (int c = 0; c < 3; c++) win[r][c] = v;
    endtask

    task automatic drive_win();
        linha1 = {8'(win[0][0]), 8'(win[0][1]), 8'(win[0][2])};
        linha2 = {8'(win[1][0]), 8'(win[1][1]), 8'(win[1][2])};
        linha3 = {8'(win[2][0]), 8'(win[2][1]), 8'(win[2][2])};
    endtask

    task automatic check_result(input string tag);
        chk({tag, "_gx0"},   gx0,   e_gx);
        chk({tag, "_gy0"},   gy0,   e_gy);
        chk({tag, "_res0"},  res0,  e_res0);
        chk({tag, "_edge0"}, edge0, e_edge0);
        chk({tag, "_gx2"},   gx2,   e_gx);
        chk({tag, "_res2"},  res2,  e_res2);
        chk({tag, "_edge2"}, edge2, e_edge2);
    endtask

    // One window: accept, measure latency, check, hold under back-pressure, release.
    task automatic run(input int md, input int thr, input int hold, input string tag);
        int cnt;
        @(negedge clk);
        drive_win();
        mode      = 2'(md);
        threshold = 8'(thr);
        in_valid  = 1'b1;
        chk({tag, "_in_ready"}, in_ready0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model(md, thr);
        cnt = 0;
        while (out_valid0 !== 1'b1 && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk({tag, "_latency"}, cnt, 10);
        chk({tag, "_ov2"}, out_valid2, 1);
        check_result(tag);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            linha1    = 24'($urandom);
            linha2    = 24'($urandom);
            linha3    = 24'($urandom);
            mode      = 2'($urandom);
            threshold = 8'($urandom);
            @(posedge clk);
            #1;
            chk({tag, "_hold_in_ready"}, in_ready0, 0);
            chk({tag, "_hold_ov"}, out_valid0, 1);
            chk({tag, "_hold_res"}, res0, e_res0);
            chk({tag, "_hold_gy"}, gy0, e_gy);
        end
        if (hold > 0) check_result({tag, "_held"});
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_ov_drop"}, out_valid0, 0);
        chk({tag, "_idle"}, busy0, 0);
        chk({tag, "_ready_again"}, in_ready0, 1);
        chk({tag, "_res_kept"}, res0, e_res0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        linha1    = '0;
        linha2    = '0;
        linha3    = '0;
        mode      = '0;
        threshold = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_in_ready", in_ready0, 0);
        chk("rst_res", res0, 0);
        chk("rst_gx", gx0, 0);
        chk("rst_edge", edge0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_release_in_ready", in_ready0, 1);

        fill_cols(100, 100, 100);
        run(0, 1, 0, "flat");
        fill_cols(255, 0, 0);
        run(0, 200, 0, "left_m0");
        run(2, 200, 0, "left_m2");
        fill_cols(0, 0, 255);
        run(1, 100, 0, "right_m1");
        fill_row(0, 0);
        fill_row(1, 0);
        fill_row(2, 200);
        run(0, 100, 0, "bot_m0");
        run(3, 100, 0, "bot_m3");
        run(1, 100, 0, "bot_m1");
        run(0, 201, 6, "bot_thr201_hold");

        // Abort mid-accumulation after a window that left nonzero outputs.
        fill_cols(255, 0, 0);
        run(0, 10, 0, "pre_abort");
        fill_cols(255, 30, 7);
        @(negedge clk);
        drive_win();
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_out_valid", out_valid0, 0);
        chk("abort_busy", busy0, 0);
        chk("abort_res", res0, 0);
        chk("abort_gx", gx0, 0);
        chk("abort_gy", gy0, 0);
        chk("abort_edge", edge0, 0);
        chk("abort_in_ready", in_ready0, 0);
        @(negedge clk);
        rst = 1'b1;
        fill_cols(50, 50, 50);
        run(0, 0, 0, "post_abort_flat");

        for (int n = 0; n < 24; n++) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] = $urandom_range(255, 0);
            run($urandom_range(3, 0), $urandom_range(255, 0), $urandom_range(3, 0), $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
